// File: rtl/game_pkg.sv
// Shared game constants, sprite sizes and the missile state encoding.
package game_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // Sprite sizes shared with the player and alien blocks.
  localparam int PLAYER_W = 32;
  localparam int PLAYER_H = 16;
  localparam int ALIEN_W  = 24;
  localparam int ALIEN_H  = 16;

  // Missile geometry and motion, in 10-bit screen coordinates.
  localparam logic [9:0] MISSILE_W = 10'd4;
  localparam logic [9:0] MISSILE_H = 10'd8;
  localparam logic [9:0] STEP_Y    = 10'd6;
  localparam logic [9:0] LAUNCH_Y  = 10'd440;

  // Frames spent reloading after the missile retires.
  localparam int         CNT_W       = 4;
  localparam logic [3:0] COOLDOWN_FR = 4'd15;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLYING   = 2'd1,
    COOLDOWN = 2'd2
  } missile_state_t;

endpackage

// File: rtl/frame_tick_gen.sv
// Brings the asynchronous VGA vertical sync into the Clk domain and emits a
// one-Clk pulse on each synchronised rising edge.
module frame_tick_gen (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_clk,
  output logic frame_tick
);

  // sync[0..1] are the synchroniser, sync[2] remembers the previous level.
  logic [2:0] sync;

  // Shift the frame clock level through the synchroniser and edge detector.
  always_ff @(posedge Clk or negedge Reset_n) begin
    // NOTE: every flop here is reset, including the synchroniser, so a
    // reset never leaves a stale level that could fake an edge.
    if (!Reset_n) begin
      sync <= '0;
    end else begin
      // NOTE: non-blocking assignment so each stage samples the previous
      // stage's old value, giving a true shift register.
      sync <= {sync[1:0], frame_clk};
    end
  end

  assign frame_tick = sync[1] & ~sync[2];

endmodule

// File: rtl/missile_controller.sv
// Single player missile: arms on a fire edge, launches on the next frame,
// climbs each frame, retires on a hit or at the top, then reloads.
module missile_controller
  import game_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       fire,
  input  logic [9:0] player_x,
  input  logic       alien_hit,
  input  logic       game_over,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic       is_missile,
  output logic       missile_active,
  output logic [9:0] missile_x,
  output logic [9:0] missile_y
);

  localparam logic [9:0] HALF_W = MISSILE_W >> 1;

  logic             frame_tick;
  missile_state_t   state_q, state_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             armed_q, armed_d;
  logic             fire_q;
  logic             fire_edge;

  frame_tick_gen u_frame_tick_gen (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_clk  (frame_clk),
    .frame_tick (frame_tick)
  );

  assign fire_edge = fire & ~fire_q;

  // State register: missile state, position, reload counter and fire latch.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      fire_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      fire_q  <= fire;
    end
  end

  // Next-state logic; game_over overrides everything, a hit beats a move.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch
    // is inferred; position holds unless a branch below moves it.
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;

    if (game_over) begin
      state_d = IDLE;
      armed_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          armed_d = armed_q | fire_edge;
          if (frame_tick && armed_q) begin
            state_d = FLYING;
            armed_d = 1'b0;
            x_d     = (player_x < HALF_W) ? 10'd0 : player_x - HALF_W;
            y_d     = LAUNCH_Y;
          end
        end
        FLYING: begin
          armed_d = armed_q | fire_edge;
          if (alien_hit) begin
            state_d = COOLDOWN;
            cnt_d   = COOLDOWN_FR;
          end else if (frame_tick) begin
            // Compare before subtracting so y never wraps below zero.
            if (y_q < STEP_Y) begin
              state_d = COOLDOWN;
              cnt_d   = COOLDOWN_FR;
            end else begin
              y_d = y_q - STEP_Y;
            end
          end
        end
        COOLDOWN: begin
          // Fire edges are dropped while reloading.
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else if (frame_tick) begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign missile_active = (state_q == FLYING);
  assign missile_x      = x_q;
  assign missile_y      = y_q;

  // Pixel hit test against the missile rectangle, widened to avoid overflow.
  always_comb begin
    is_missile = 1'b0;
    if (missile_active &&
        ({1'b0, DrawX} >= {1'b0, x_q}) &&
        ({1'b0, DrawX} <  ({1'b0, x_q} + {1'b0, MISSILE_W})) &&
        ({1'b0, DrawY} >= {1'b0, y_q}) &&
        ({1'b0, DrawY} <  ({1'b0, y_q} + {1'b0, MISSILE_H}))) begin
      is_missile = 1'b1;
    end
  end

endmodule

// File: tb/tb_missile_controller.sv
// Directed bench for missile_controller: launch, flight to the top, hit,
// reload, held fire, edge saturation, game over and asynchronous reset.
module tb_missile_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_clk;
  logic       fire;
  logic [9:0] player_x;
  logic       alien_hit;
  logic       game_over;
  logic [9:0] draw_x;
  logic [9:0] draw_y;
  logic       is_missile;
  logic       missile_active;
  logic [9:0] missile_x;
  logic [9:0] missile_y;

  int total = 0;
  int bad   = 0;
  int launches = 0;
  logic active_prev = 1'b0;

  missile_controller dut (
    .Clk            (clk),
    .Reset_n        (rst_n),
    .frame_clk      (frame_clk),
    .fire           (fire),
    .player_x       (player_x),
    .alien_hit      (alien_hit),
    .game_over      (game_over),
    .DrawX          (draw_x),
    .DrawY          (draw_y),
    .is_missile     (is_missile),
    .missile_active (missile_active),
    .missile_x      (missile_x),
    .missile_y      (missile_y)
  );

  always #5 clk = ~clk;

  // Count launches as rising edges of missile_active.
  always @(posedge clk) begin
    active_prev <= missile_active;
    if (missile_active && !active_prev) launches <= launches + 1;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One VGA frame: frame_clk high for 5 Clk, low for 5 Clk.
  task automatic frame();
    frame_clk = 1'b1;
    wait_clks(5);
    frame_clk = 1'b0;
    wait_clks(5);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic press_fire();
    fire = 1'b1;
    wait_clks(2);
    fire = 1'b0;
    wait_clks(2);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    frame_clk = 1'b0;
    fire      = 1'b0;
    alien_hit = 1'b0;
    game_over = 1'b0;
    player_x  = 10'd0;
    draw_x    = 10'd0;
    draw_y    = 10'd0;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(2);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    frame_clk = 1'b0;
    fire      = 1'b0;
    alien_hit = 1'b0;
    game_over = 1'b0;
    player_x  = 10'd320;
    draw_x    = 10'd0;
    draw_y    = 10'd0;
    wait_clks(2);
    total++;
    if (missile_active !== 1'b0) begin
      bad++; $display("FAIL reset_active: got %b expected 0", missile_active);
    end
    total++;
    if (missile_x !== 10'd0) begin
      bad++; $display("FAIL reset_x: got %0d expected 0", missile_x);
    end
    total++;
    if (missile_y !== 10'd0) begin
      bad++; $display("FAIL reset_y: got %0d expected 0", missile_y);
    end
    total++;
    if (is_missile !== 1'b0) begin
      bad++; $display("FAIL reset_pixel: got %b expected 0", is_missile);
    end
    rst_n = 1'b1;
    wait_clks(2);
  endtask

  task automatic test_launch();
    player_x = 10'd320;
    press_fire();
    total++;
    if (missile_active !== 1'b0) begin
      bad++; $display("FAIL launch_wait_frame: got %b expected 0", missile_active);
    end
    frame();
    total++;
    if (missile_active !== 1'b1) begin
      bad++; $display("FAIL launch_active: got %b expected 1", missile_active);
    end
    total++;
    if (missile_x !== 10'd318) begin
      bad++; $display("FAIL launch_x: got %0d expected 318", missile_x);
    end
    total++;
    if (missile_y !== 10'd440) begin
      bad++; $display("FAIL launch_y: got %0d expected 440", missile_y);
    end
    draw_x = 10'd318; draw_y = 10'd440; #1;
    total++;
    if (is_missile !== 1'b1) begin
      bad++; $display("FAIL pixel_318_440: got %b expected 1", is_missile);
    end
    draw_x = 10'd321; draw_y = 10'd447; #1;
    total++;
    if (is_missile !== 1'b1) begin
      bad++; $display("FAIL pixel_321_447: got %b expected 1", is_missile);
    end
    draw_x = 10'd322; draw_y = 10'd440; #1;
    total++;
    if (is_missile !== 1'b0) begin
      bad++; $display("FAIL pixel_322_440: got %b expected 0", is_missile);
    end
    draw_x = 10'd318; draw_y = 10'd448; #1;
    total++;
    if (is_missile !== 1'b0) begin
      bad++; $display("FAIL pixel_318_448: got %b expected 0", is_missile);
    end
  endtask

  // Continues from the launch at y=440.
  task automatic test_flight_top();
    frames(73);
    total++;
    if (missile_y !== 10'd2) begin
      bad++; $display("FAIL top_y_after_73: got %0d expected 2", missile_y);
    end
    total++;
    if (missile_active !== 1'b1) begin
      bad++; $display("FAIL top_active_after_73: got %b expected 1", missile_active);
    end
    frame();
    total++;
    if (missile_active !== 1'b0) begin
      bad++; $display("FAIL top_exit_active: got %b expected 0", missile_active);
    end
    total++;
    if (missile_y !== 10'd2) begin
      bad++; $display("FAIL top_exit_y_hold: got %0d expected 2", missile_y);
    end
    total++;
    if (missile_x !== 10'd318) begin
      bad++; $display("FAIL top_exit_x_hold: got %0d expected 318", missile_x);
    end
    frames(14);
    press_fire();
    frame();
    total++;
    if (missile_active !== 1'b0) begin
      bad++; $display("FAIL cooldown_15th_frame: got %b expected 0", missile_active);
    end
    frame();
    total++;
    if (missile_active !== 1'b0) begin
      bad++; $display("FAIL cooldown_fire_dropped: got %b expected 0", missile_active);
    end
    press_fire();
    frame();
    total++;
    if (missile_active !== 1'b1) begin
      bad++; $display("FAIL relaunch_after_cooldown: got %b expected 1", missile_active);
    end
    total++;
    if (missile_y !== 10'd440) begin
      bad++; $display("FAIL relaunch_y: got %0d expected 440", missile_y);
    end
  endtask

  task automatic test_hit_cooldown();
    apply_reset();
    player_x = 10'd100;
    press_fire();
    frame();
    frames(3);
    total++;
    if (missile_y !== 10'd422) begin
      bad++; $display("FAIL hit_pre_y: got %0d expected 422", missile_y);
    end
    // The synchronised tick is live during the third Clk edge after frame_clk rises.
    frame_clk = 1'b1;
    @(negedge clk);
    @(negedge clk);
    alien_hit = 1'b1;
    @(negedge clk);
    alien_hit = 1'b0;
    total++;
    if (missile_active !== 1'b0) begin
      bad++; $display("FAIL hit_with_tick_active: got %b expected 0", missile_active);
    end
    total++;
    if (missile_y !== 10'd422) begin
      bad++; $display("FAIL hit_with_tick_y: got %0d expected 422", missile_y);
    end
    wait_clks(2);
    frame_clk = 1'b0;
    wait_clks(5);
    press_fire();
    frames(15);
    total++;
    if (missile_active !== 1'b0) begin
      bad++; $display("FAIL hit_cooldown_active: got %b expected 0", missile_active);
    end
    frame();
    total++;
    if (missile_active !== 1'b0) begin
      bad++; $display("FAIL hit_cooldown_fire_dropped: got %b expected 0", missile_active);
    end
    // A hit while idle must not start a cooldown.
    alien_hit = 1'b1;
    wait_clks(1);
    alien_hit = 1'b0;
    press_fire();
    frame();
    total++;
    if (missile_active !== 1'b1) begin
      bad++; $display("FAIL idle_hit_ignored: got %b expected 1", missile_active);
    end
  endtask

  task automatic test_hold_fire();
    int base;
    apply_reset();
    player_x = 10'd200;
    base = launches;
    fire = 1'b1;
    frame();
    frames(2);
    alien_hit = 1'b1;
    wait_clks(1);
    alien_hit = 1'b0;
    total++;
    if (missile_active !== 1'b0) begin
      bad++; $display("FAIL hit_one_clk: got %b expected 0", missile_active);
    end
    frames(37);
    total++;
    if (launches - base !== 1) begin
      bad++; $display("FAIL hold_fire_launches: got %0d expected 1", launches - base);
    end
    fire = 1'b0;
    wait_clks(2);
    fire = 1'b1;
    wait_clks(2);
    frame();
    total++;
    if (missile_active !== 1'b1) begin
      bad++; $display("FAIL repress_active: got %b expected 1", missile_active);
    end
    total++;
    if (launches - base !== 2) begin
      bad++; $display("FAIL repress_launches: got %0d expected 2", launches - base);
    end
    fire = 1'b0;
  endtask

  task automatic test_saturate();
    apply_reset();
    player_x = 10'd1;
    press_fire();
    frame();
    total++;
    if (missile_x !== 10'd0) begin
      bad++; $display("FAIL sat_x: got %0d expected 0", missile_x);
    end
    draw_x = 10'd3; draw_y = 10'd440; #1;
    total++;
    if (is_missile !== 1'b1) begin
      bad++; $display("FAIL sat_pixel_3_440: got %b expected 1", is_missile);
    end
    draw_x = 10'd4; draw_y = 10'd440; #1;
    total++;
    if (is_missile !== 1'b0) begin
      bad++; $display("FAIL sat_pixel_4_440: got %b expected 0", is_missile);
    end
    draw_x = 10'd0; draw_y = 10'd439; #1;
    total++;
    if (is_missile !== 1'b0) begin
      bad++; $display("FAIL sat_pixel_0_439: got %b expected 0", is_missile);
    end
  endtask

  task automatic test_game_over();
    apply_reset();
    player_x = 10'd320;
    press_fire();
    frame();
    frames(2);
    draw_x = 10'd318; draw_y = 10'd428; #1;
    total++;
    if (is_missile !== 1'b1) begin
      bad++; $display("FAIL go_pre_pixel: got %b expected 1", is_missile);
    end
    @(negedge clk);
    game_over = 1'b1;
    wait_clks(1);
    total++;
    if (missile_active !== 1'b0) begin
      bad++; $display("FAIL go_active: got %b expected 0", missile_active);
    end
    total++;
    if (is_missile !== 1'b0) begin
      bad++; $display("FAIL go_pixel: got %b expected 0", is_missile);
    end
    press_fire();
    frames(2);
    total++;
    if (missile_active !== 1'b0) begin
      bad++; $display("FAIL go_fire_blocked: got %b expected 0", missile_active);
    end
    game_over = 1'b0;
    frames(2);
    total++;
    if (missile_active !== 1'b0) begin
      bad++; $display("FAIL go_fire_not_kept: got %b expected 0", missile_active);
    end
    press_fire();
    frame();
    total++;
    if (missile_active !== 1'b1) begin
      bad++; $display("FAIL go_recover: got %b expected 1", missile_active);
    end
  endtask

  // Continues from the in-flight missile left by test_game_over.
  task automatic test_async_reset();
    draw_x = missile_x; draw_y = 10'd440;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (missile_active !== 1'b0) begin
      bad++; $display("FAIL async_rst_active: got %b expected 0", missile_active);
    end
    total++;
    if (missile_x !== 10'd0) begin
      bad++; $display("FAIL async_rst_x: got %0d expected 0", missile_x);
    end
    total++;
    if (missile_y !== 10'd0) begin
      bad++; $display("FAIL async_rst_y: got %0d expected 0", missile_y);
    end
    total++;
    if (is_missile !== 1'b0) begin
      bad++; $display("FAIL async_rst_pixel: got %b expected 0", is_missile);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_clks(2);
  endtask

  initial begin
    test_reset();
    test_launch();
    test_flight_top();
    test_hit_cooldown();
    test_hold_fire();
    test_saturate();
    test_game_over();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
